// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the controller state encoding, address width and requester count.
package mem_arbiter_pkg;
    localparam int ADDR_W = 4;
    localparam int N_REQ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: one-hot winner, the port not served last wins a tie.
// Purely combinational; a lone requester always wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin pick in IDLE, one-cycle command, read return.
// gnt at +1, rvalid at +3; requests are only sampled in IDLE, so requesters hold until gnt.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int w = 7,
    parameter int l = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wrt_read0,
    input  logic              wrt_read1,
    input  logic [ADDR_W-1:0] add0,
    input  logic [ADDR_W-1:0] add1,
    input  logic [w:0]        write0,
    input  logic [w:0]        write1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [w:0]        rdata0,
    output logic [w:0]        rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_enable,
    output logic              mem_wrt_read,
    output logic [ADDR_W-1:0] mem_add,
    output logic [w:0]        mem_write,
    input  logic [w:0]        mem_out
);

    state_t              state, state_nxt;
    logic                owner;
    logic                last;
    logic                lat_wr;
    logic [ADDR_W-1:0]   lat_add;
    logic [w:0]          lat_dat;
    logic [N_REQ-1:0]    win;
    logic                addr_bad;

    rr_arb2 u_rr_arb2 (
        .req   ({req1, req0}),
        .last  (last),
        .grant (win)
    );

    assign addr_bad = int'(lat_add) >= l;

    always_comb begin
        state_nxt    = state;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        err0         = 1'b0;
        err1         = 1'b0;
        mem_enable   = 1'b0;
        mem_wrt_read = 1'b0;
        mem_add      = '0;
        mem_write    = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = CMD;
            end
            CMD: begin
                gnt0 = !owner;
                gnt1 = owner;
                if (addr_bad) begin
                    // Bad address: acknowledge and flag, but never touch memory.
                    err0      = !owner;
                    err1      = owner;
                    state_nxt = IDLE;
                end else begin
                    mem_enable   = 1'b1;
                    mem_wrt_read = lat_wr;
                    mem_add      = lat_add;
                    mem_write    = lat_dat;
                    state_nxt    = lat_wr ? IDLE : RD;
                end
            end
            RD:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            lat_wr  <= 1'b0;
            lat_add <= '0;
            lat_dat <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == IDLE && (req0 || req1)) begin
                owner   <= win[1];
                lat_wr  <= win[0] ? wrt_read0 : wrt_read1;
                lat_add <= win[0] ? add0 : add1;
                lat_dat <= win[0] ? write0 : write1;
            end
            if (state == CMD) last <= owner;
            // Memory returns read data during RD; capture it as that cycle ends.
            if (state == RD) begin
                if (owner) begin
                    rdata1  <= mem_out;
                    rvalid1 <= 1'b1;
                end else begin
                    rdata0  <= mem_out;
                    rvalid0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order, timing and read data.
module tb_mem_arbiter;
    localparam int W = 7;
    localparam int L = 10;

    typedef struct { bit wr; logic [3:0] add; logic [W:0] dat; } txn_t;
    typedef struct { int port; int gcyc; bit err; bit wr; logic [3:0] add; logic [W:0] wdat; } gexp_t;
    typedef struct { int port; int cyc; logic [W:0] dat; } rexp_t;

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, wrt_read0, wrt_read1;
    logic [3:0] add0, add1;
    logic [W:0] write0, write1;
    logic gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [W:0] rdata0, rdata1;
    logic mem_enable, mem_wrt_read;
    logic [3:0] mem_add;
    logic [W:0] mem_write;
    logic [W:0] mem_out;

    logic [W:0] mem [16];
    logic [W:0] ref_mem [16];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int ref_last;
    txn_t q0[$], q1[$];
    gexp_t gexp_q[$];
    rexp_t rexp_q[$];

    mem_arbiter #(.w(W), .l(L)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .wrt_read0(wrt_read0), .wrt_read1(wrt_read1),
        .add0(add0), .add1(add1),
        .write0(write0), .write1(write1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_enable(mem_enable), .mem_wrt_read(mem_wrt_read),
        .mem_add(mem_add), .mem_write(mem_write),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: read data appears one cycle after the read command.
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_wrt_read) mem[mem_add] <= mem_write;
            else              mem_out <= mem[mem_add];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic txn_t mk(input bit wr, input int a, input int d);
        txn_t t;
        t.wr = wr; t.add = 4'(a); t.dat = 8'(d);
        return t;
    endfunction

    task automatic present();
        req0 = q0.size() != 0;
        if (q0.size() != 0) begin
            wrt_read0 = q0[0].wr; add0 = q0[0].add; write0 = q0[0].dat;
        end
        req1 = q1.size() != 0;
        if (q1.size() != 0) begin
            wrt_read1 = q1[0].wr; add1 = q1[0].add; write1 = q1[0].dat;
        end
    endtask

    // Predicts service order and timing for back-to-back requests from both queues,
    // then drives them; call at a negedge with the DUT idle.
    task automatic run_phase();
        txn_t m0[$], m1[$];
        txn_t x;
        int t, p, budget;
        bit bad;
        m0 = q0; m1 = q1; t = cyc;
        while (m0.size() != 0 || m1.size() != 0) begin
            if (m0.size() != 0 && m1.size() != 0) p = (ref_last == 0) ? 1 : 0;
            else p = (m0.size() != 0) ? 0 : 1;
            x = (p == 1) ? m1.pop_front() : m0.pop_front();
            ref_last = p;
            bad = int'(x.add) >= L;
            gexp_q.push_back('{p, t + 1, bad, x.wr, x.add, x.dat});
            if (!bad && x.wr) ref_mem[x.add] = x.dat;
            if (!bad && !x.wr) begin
                rexp_q.push_back('{p, t + 3, ref_mem[x.add]});
                t += 3;
            end else begin
                t += 2;
            end
        end
        present();
        budget = 200;
        while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (gnt0 && q0.size() != 0) void'(q0.pop_front());
            if (gnt1 && q1.size() != 0) void'(q1.pop_front());
            present();
        end
        if (budget == 0) begin
            fail_now("grant_timeout");
            q0.delete(); q1.delete();
            present();
        end
        budget = 20;
        while ((gexp_q.size() != 0 || rexp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        if (gexp_q.size() != 0 || rexp_q.size() != 0) begin
            fail_now("response_timeout");
            gexp_q.delete(); rexp_q.delete();
        end
    endtask

    // Monitor: compares every grant/err/rvalid against the predicted queues.
    initial begin
        gexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gnt0 && gnt1) fail_now("two_gnt");
            if (rvalid0 && rvalid1) fail_now("two_rvalid");
            if (gnt0 || gnt1) begin
                if (gexp_q.size() == 0) fail_now("unexpected_gnt");
                else begin
                    e = gexp_q.pop_front();
                    chk("gnt_port", 32'(gnt1), 32'(e.port));
                    chk("gnt_cycle", 32'(cyc), 32'(e.gcyc));
                    chk("err_flag", 32'(e.port == 1 ? err1 : err0), 32'(e.err));
                    chk("err_other", 32'(e.port == 1 ? err0 : err1), 0);
                    chk("mem_enable", 32'(mem_enable), 32'(!e.err));
                    if (!e.err) begin
                        chk("mem_wrt_read", 32'(mem_wrt_read), 32'(e.wr));
                        chk("mem_add", 32'(mem_add), 32'(e.add));
                        chk("mem_write", 32'(mem_write), 32'(e.wdat));
                    end
                end
            end else if (err0 || err1) begin
                fail_now("err_without_gnt");
            end
            if (!mem_enable && (mem_wrt_read || mem_add != 0 || mem_write != 0))
                fail_now("mem_bus_not_zero");
            if (rvalid0 || rvalid1) begin
                if (rexp_q.size() == 0) fail_now("unexpected_rvalid");
                else begin
                    r = rexp_q.pop_front();
                    chk("rvalid_port", 32'(rvalid1), 32'(r.port));
                    chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rdata", 32'(rvalid1 ? rdata1 : rdata0), 32'(r.dat));
                end
            end
        end
    end

    initial begin
        int s;
        for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem_out = '0;
        reset = 1'b1;
        req0 = 0; req1 = 0; wrt_read0 = 0; wrt_read1 = 0;
        add0 = '0; add1 = '0; write0 = '0; write1 = '0;
        ref_last = 1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'({gnt0, gnt1}), 0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1}), 0);
        chk("rst_err", 32'({err0, err1}), 0);
        chk("rst_mem", 32'({mem_enable, mem_wrt_read, mem_add, mem_write}), 0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Write then read on port 0.
        q0.push_back(mk(1, 0, 10));
        q0.push_back(mk(0, 0, 0));
        run_phase();

        // Preload 33 and 66 with a write tie.
        q0.push_back(mk(1, 1, 33));
        q1.push_back(mk(1, 2, 66));
        run_phase();

        // Reset lands in the RD cycle of a port-1 read.
        s = cyc;
        req1 = 1; wrt_read1 = 0; add1 = 4'd3; write1 = 8'h5a;
        gexp_q.push_back('{1, s + 1, 1'b0, 1'b0, 4'd3, 8'h5a});
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_last = 1;
        chk("midrd_rvalid", 32'({rvalid0, rvalid1}), 0);
        chk("midrd_gnt_err", 32'({gnt0, gnt1, err0, err1}), 0);
        chk("midrd_mem", 32'({mem_enable, mem_wrt_read, mem_add, mem_write}), 0);
        chk("midrd_rdata", 32'({rdata0, rdata1}), 0);
        @(negedge clk);

        // Read tie straight after reset: port 0 first, data 33 then 66.
        q0.push_back(mk(0, 1, 0));
        q1.push_back(mk(0, 2, 0));
        run_phase();

        // Fairness: both held for six transactions.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(4, 9), $urandom_range(0, 255)));
            q1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(4, 9), $urandom_range(0, 255)));
        end
        run_phase();

        // Out-of-range read on port 1.
        q1.push_back(mk(0, 12, 0));
        run_phase();

        for (int ph = 0; ph < 12; ph++) begin
            int n0, n1;
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(0, 4);
            for (int i = 0; i < n0; i++)
                q0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255)));
            for (int i = 0; i < n1; i++)
                q1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255)));
            run_phase();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
